// File: rtl/marie_ctrl_seq.sv
// MARIE control sequencer: fetch/decode/execute FSM driving register CE strobes,
// the shared-bus source select, the INPUT/OUTPUT handshakes and HALT.
module marie_ctrl_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] ir_op,
  input  logic [1:0] ir_cond,
  input  logic       ac_neg,
  input  logic       ac_zero,
  input  logic       ac_pos,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic [2:0] bus_sel,
  output logic       ld_mar,
  output logic       ld_pc,
  output logic       ld_ir,
  output logic       ld_mbr,
  output logic       ld_ac,
  output logic       ld_out,
  output logic       inc_pc,
  output logic       clr_ac,
  output logic [1:0] alu_op,
  output logic       mem_wr,
  output logic       in_ack,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_D0, S_E0, S_E1, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_INPUT = 4'h5;
  localparam logic [3:0] OP_OUTPT = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_PC   = 3'b001;
  localparam logic [2:0] BUS_IR   = 3'b010;
  localparam logic [2:0] BUS_MEM  = 3'b011;
  localparam logic [2:0] BUS_MBR  = 3'b100;
  localparam logic [2:0] BUS_AC   = 3'b101;
  localparam logic [2:0] BUS_IN   = 3'b110;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  state_t state, state_nx;

  function automatic logic skip_taken(input logic [1:0] cond, input logic neg,
                                      input logic zero, input logic pos);
    case (cond)
      2'b00:   skip_taken = neg;
      2'b01:   skip_taken = zero;
      2'b10:   skip_taken = pos;
      default: skip_taken = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (run) state_nx = S_F0;
      S_F0:   state_nx = S_F1;
      S_F1:   state_nx = S_D0;
      S_D0:   state_nx = S_E0;
      S_E0: begin
        case (ir_op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUBT: state_nx = S_E1;
          OP_INPUT: if (in_valid)  state_nx = S_F0;
          OP_OUTPT: if (out_ready) state_nx = S_F0;
          OP_HALT:  state_nx = S_HALT;
          default:  state_nx = S_F0;
        endcase
      end
      S_E1:    state_nx = S_F0;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus_sel = BUS_NONE;
    ld_mar  = 1'b0;
    ld_pc   = 1'b0;
    ld_ir   = 1'b0;
    ld_mbr  = 1'b0;
    ld_ac   = 1'b0;
    ld_out  = 1'b0;
    inc_pc  = 1'b0;
    clr_ac  = 1'b0;
    alu_op  = ALU_PASS;
    mem_wr  = 1'b0;
    in_ack  = 1'b0;
    halted  = 1'b0;
    case (state)
      S_F0: begin bus_sel = BUS_PC;  ld_mar = 1'b1; end
      S_F1: begin bus_sel = BUS_MEM; ld_ir = 1'b1; inc_pc = 1'b1; end
      S_D0: begin bus_sel = BUS_IR;  ld_mar = 1'b1; end
      S_E0: begin
        case (ir_op)
          OP_LOAD, OP_ADD, OP_SUBT: begin bus_sel = BUS_MEM; ld_mbr = 1'b1; end
          OP_STORE: begin bus_sel = BUS_AC; ld_mbr = 1'b1; end
          OP_INPUT: if (in_valid) begin
            bus_sel = BUS_IN;
            ld_ac   = 1'b1;
            in_ack  = 1'b1;
          end
          OP_OUTPT: if (out_ready) begin bus_sel = BUS_AC; ld_out = 1'b1; end
          OP_SKIP:  inc_pc = skip_taken(ir_cond, ac_neg, ac_zero, ac_pos);
          OP_JUMP:  begin bus_sel = BUS_IR; ld_pc = 1'b1; end
          OP_CLEAR: clr_ac = 1'b1;
          default: ;
        endcase
      end
      S_E1: begin
        case (ir_op)
          OP_LOAD:  begin bus_sel = BUS_MBR; ld_ac = 1'b1; alu_op = ALU_PASS; end
          OP_ADD:   begin bus_sel = BUS_MBR; ld_ac = 1'b1; alu_op = ALU_ADD;  end
          OP_SUBT:  begin bus_sel = BUS_MBR; ld_ac = 1'b1; alu_op = ALU_SUB;  end
          OP_STORE: mem_wr = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_marie_ctrl_seq.sv
// Scoreboard bench for marie_ctrl_seq: per-cycle expected output vectors are
// queued as stimulus is applied and compared against the packed DUT outputs.
module tb_marie_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] ir_op = 4'h0;
  logic [1:0] ir_cond = 2'b00;
  logic       ac_neg = 1'b0, ac_zero = 1'b0, ac_pos = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] bus_sel;
  logic       ld_mar, ld_pc, ld_ir, ld_mbr, ld_ac, ld_out, inc_pc, clr_ac;
  logic [1:0] alu_op;
  logic       mem_wr, in_ack, halted;

  marie_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir_op(ir_op), .ir_cond(ir_cond),
    .ac_neg(ac_neg), .ac_zero(ac_zero), .ac_pos(ac_pos),
    .in_valid(in_valid), .out_ready(out_ready), .bus_sel(bus_sel),
    .ld_mar(ld_mar), .ld_pc(ld_pc), .ld_ir(ld_ir), .ld_mbr(ld_mbr),
    .ld_ac(ld_ac), .ld_out(ld_out), .inc_pc(inc_pc), .clr_ac(clr_ac),
    .alu_op(alu_op), .mem_wr(mem_wr), .in_ack(in_ack), .halted(halted)
  );

  always #5 clk = ~clk;

  // Packed view: {bus_sel, ld_mar, ld_pc, ld_ir, ld_mbr, ld_ac, ld_out, inc_pc, clr_ac, alu_op, mem_wr, in_ack, halted}
  logic [15:0] obs;
  assign obs = {bus_sel, ld_mar, ld_pc, ld_ir, ld_mbr, ld_ac, ld_out,
                inc_pc, clr_ac, alu_op, mem_wr, in_ack, halted};

  localparam logic [15:0] S_PC  = 16'h2000, S_IR  = 16'h4000, S_MEM = 16'h6000;
  localparam logic [15:0] S_MBR = 16'h8000, S_AC  = 16'hA000, S_IN  = 16'hC000;
  localparam logic [15:0] M_MAR = 16'h1000, M_PC  = 16'h0800, M_IR  = 16'h0400;
  localparam logic [15:0] M_MBR = 16'h0200, M_AC  = 16'h0100, M_OUT = 16'h0080;
  localparam logic [15:0] M_INC = 16'h0040, M_CLR = 16'h0020, A_ADD = 16'h0008;
  localparam logic [15:0] A_SUB = 16'h0010, M_WR  = 16'h0004, M_ACK = 16'h0002;
  localparam logic [15:0] M_HLT = 16'h0001;
  localparam logic [15:0] F0V = S_PC | M_MAR;
  localparam logic [15:0] F1V = S_MEM | M_IR | M_INC;
  localparam logic [15:0] D0V = S_IR | M_MAR;

  logic [15:0] exp_q [$];
  logic [15:0] expv;
  int checks = 0;
  int errors = 0;

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (i == 10) run = 1'b1;
      exp_q.push_back(16'h0000);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_mem_op(input logic [3:0] op, input logic [15:0] e0, input logic [15:0] e1,
                             input string name);
    logic [15:0] seq [$];
    seq = '{F0V, F1V, D0V, e0, e1};
    foreach (seq[i]) begin
      @(negedge clk);
      if (i == 1) ir_op = op;
      exp_q.push_back(seq[i]);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cyc%0d got %h expected %h", name, i, obs, expv);
      end
    end
  endtask

  task automatic test_skipcond();
    logic [1:0]  conds [5] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [2:0]  flags [5] = '{3'b010, 3'b101, 3'b111, 3'b100, 3'b001};
    logic [15:0] e0s   [5] = '{M_INC, 16'h0000, 16'h0000, M_INC, M_INC};
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 1) begin
          ir_op = 4'h8;
          ir_cond = conds[k];
          {ac_neg, ac_zero, ac_pos} = flags[k];
        end
        exp_q.push_back(i == 0 ? F0V : i == 1 ? F1V : i == 2 ? D0V : e0s[k]);
        #1;
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL skipcond case%0d cyc%0d got %h expected %h", k, i, obs, expv);
        end
      end
    end
  endtask

  task automatic test_short_ops();
    logic [3:0]  ops [4] = '{4'h9, 4'hA, 4'h0, 4'hF};
    logic [15:0] e0s [4] = '{S_IR | M_PC, M_CLR, 16'h0000, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 1) ir_op = ops[k];
        exp_q.push_back(i == 0 ? F0V : i == 1 ? F1V : i == 2 ? D0V : e0s[k]);
        #1;
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL short_op op%h cyc%0d got %h expected %h", ops[k], i, obs, expv);
        end
      end
    end
  endtask

  task automatic test_input();
    logic [15:0] seq [$];
    seq = '{F0V, F1V, D0V, 16'h0000, 16'h0000, 16'h0000, S_IN | M_AC | M_ACK};
    foreach (seq[i]) begin
      @(negedge clk);
      if (i == 1) begin ir_op = 4'h5; in_valid = 1'b0; end
      if (i == 6) in_valid = 1'b1;
      exp_q.push_back(seq[i]);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL input cyc%0d got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_output();
    logic [15:0] seq [$];
    seq = '{F0V, F1V, D0V, 16'h0000, 16'h0000, S_AC | M_OUT};
    foreach (seq[i]) begin
      @(negedge clk);
      if (i == 1) begin ir_op = 4'h6; out_ready = 1'b0; end
      if (i == 5) out_ready = 1'b1;
      exp_q.push_back(seq[i]);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL output cyc%0d got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] seq [$];
    seq = '{F0V, F1V, D0V, S_MEM | M_MBR, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    foreach (seq[i]) begin
      @(negedge clk);
      if (i == 1) ir_op = 4'h1;
      if (i == 3) begin rst_n = 1'b0; run = 1'b0; end
      if (i == 4) rst_n = 1'b1;
      exp_q.push_back(seq[i]);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_mid cyc%0d got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] seq [$];
    seq = '{16'h0000, F0V, F1V, D0V, 16'h0000};
    for (int i = 0; i < 8; i++) seq.push_back(M_HLT);
    foreach (seq[i]) begin
      @(negedge clk);
      if (i == 0) run = 1'b1;
      if (i == 2) ir_op = 4'h7;
      if (i >= 5) run = ~run;
      exp_q.push_back(seq[i]);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL halt cyc%0d got %h expected %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem_op(4'h1, S_MEM | M_MBR, S_MBR | M_AC, "load");
    test_mem_op(4'h3, S_MEM | M_MBR, S_MBR | M_AC | A_ADD, "add");
    test_mem_op(4'h4, S_MEM | M_MBR, S_MBR | M_AC | A_SUB, "subt");
    test_mem_op(4'h2, S_AC | M_MBR, M_WR, "store");
    test_mem_op(4'h1, S_MEM | M_MBR, S_MBR | M_AC, "load_b2b");
    test_skipcond();
    test_short_ops();
    test_input();
    test_output();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
